// File: rtl/fb_scanout.sv
// Purpose : VGA timing generator and double-buffered frame-memory scanout, each stored pixel upscaled 2^SCALE_SHIFT x 2^SCALE_SHIFT.
// Latency : 3 clk from the h/v counters to RGB/de/hsync/vsync; frame memory read data returns 1 clk after fb_addr.
// Backpressure: none, because the pixel clock free-runs. Buffer swaps wait for the start of vertical blank (swap_req level, swap_ack pulse).
//
// Ports:
//   clk, rst            pixel clock; asynchronous active-high reset
//   fb_addr, fb_rd_en   registered frame-memory read address and enable (enable is high only for active pixels)
//   fb_data             {R,G,B} 4 bits each, valid 1 clk after fb_addr
//   swap_req, swap_ack  tracer swap request (level) and its acknowledge (1-clk pulse)
//   front_buf           buffer being displayed; the tracer renders into ~front_buf
//   vgaRed/Green/Blue   pixel colour; zero outside the active region
//   hsync, vsync, de    active-low syncs and display enable, aligned with RGB
//   vblank              v_cnt in vertical blanking (counter domain, not delayed)
module fb_scanout #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_rd_en,
   input  logic [11:0]       fb_data,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              front_buf,
   output logic [3:0]        vgaRed,
   output logic [3:0]        vgaGreen,
   output logic [3:0]        vgaBlue,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              vblank
);

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FB_W      = H_ACTIVE >> SCALE_SHIFT;
   localparam int FB_H      = V_ACTIVE >> SCALE_SHIFT;
   localparam int FB_PIXELS = FB_W * FB_H;
   localparam int H_W       = $clog2(H_TOTAL);
   localparam int V_W       = $clog2(V_TOTAL);

   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [H_W-1:0]    h_cnt;
   logic [V_W-1:0]    v_cnt;
   logic              act, hs_n, vs_n, vb_start;
   logic [ADDR_W-1:0] addr_nxt;
   logic              de_d1, hs_d1, vs_d1;
   logic              de_d2, hs_d2, vs_d2;
   logic [11:0]       rgb_q;

   // Raster counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
      end else begin
         h_cnt <= h_cnt + H_W'(1);
      end
   end

   // Stage 0: region decode and address, all from the counters
   always_comb begin
      act      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_n     = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
      vs_n     = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
      vb_start = (h_cnt == '0) && (v_cnt == V_ACT);
      vblank   = (v_cnt >= V_ACT);
      // Dropping the low SCALE_SHIFT bits of each counter repeats every stored
      // pixel across a 2^SCALE_SHIFT square of screen pixels.
      addr_nxt = (front_buf ? ADDR_W'(FB_PIXELS) : '0)
               + ADDR_W'(v_cnt >> SCALE_SHIFT) * ADDR_W'(FB_W)
               + ADDR_W'(h_cnt >> SCALE_SHIFT);
   end

   // Stage 1: memory request. The address holds through blanking so that the
   // memory side sees no spurious toggling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_addr  <= '0;
         fb_rd_en <= 1'b0;
         de_d1    <= 1'b0;
         hs_d1    <= 1'b1;
         vs_d1    <= 1'b1;
      end else begin
         if (act) fb_addr <= addr_nxt;
         fb_rd_en <= act;
         de_d1    <= act;
         hs_d1    <= hs_n;
         vs_d1    <= vs_n;
      end
   end

   // Stage 2: fb_data is valid here. Stage 3: output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_d2 <= 1'b0;
         hs_d2 <= 1'b1;
         vs_d2 <= 1'b1;
         rgb_q <= '0;
         de    <= 1'b0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         de_d2 <= de_d1;
         hs_d2 <= hs_d1;
         vs_d2 <= vs_d1;
         rgb_q <= de_d2 ? fb_data : 12'h000;
         de    <= de_d2;
         hsync <= hs_d2;
         vsync <= vs_d2;
      end
   end

   assign {vgaRed, vgaGreen, vgaBlue} = rgb_q;

   // Swaps are sampled only at vblank start. This keeps front_buf fixed across
   // every active region and allows at most one swap per frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         front_buf <= 1'b0;
         swap_ack  <= 1'b0;
      end else begin
         swap_ack <= vb_start && swap_req;
         if (vb_start && swap_req) front_buf <= ~front_buf;
      end
   end

endmodule
